// File: rtl/serial_frame_store_pkg.sv
// Shared definitions for the serial frame store: state encoding and default sizes.
package serial_frame_store_pkg;

    localparam int unsigned DEF_COUNTER_SIZE = 4;
    localparam int unsigned DEF_BUFFER_SIZE  = 16;

    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

endpackage

// File: rtl/serial_frame_store_if.sv
// Output frame handshake between the store and its consumer.
// STORE_PARITY_EN adds buffer_parity alongside buffer.
interface serial_frame_store_if #(
    parameter int unsigned buffer_size = 16
);
    logic                   out_valid;
    logic                   out_ready;
    logic [buffer_size-1:0] buffer;
`ifdef STORE_PARITY_EN
    logic                   buffer_parity;

    modport master (output out_valid, output buffer, output buffer_parity, input out_ready);
    modport slave  (input out_valid, input buffer, input buffer_parity, output out_ready);
`else
    modport master (output out_valid, output buffer, input out_ready);
    modport slave  (input out_valid, input buffer, output out_ready);
`endif
endinterface

// File: rtl/serial_frame_store_bit_write_decoder.sv
// Decodes the strobed bit index and merges the write into the fill bank, mask and count.
module bit_write_decoder #(
    parameter int unsigned counter_size = 4,
    parameter int unsigned buffer_size  = 16
) (
    input  logic                    oeenable,
    input  logic [2*counter_size:0] ramadrs,
    input  logic                    txda,
    input  logic [buffer_size-1:0]  bank_q,
    input  logic [buffer_size-1:0]  mask_q,
    input  logic [counter_size:0]   fill_count_q,
    output logic                    write_en,
    output logic [buffer_size-1:0]  bank_merged,
    output logic [buffer_size-1:0]  mask_merged,
    output logic [counter_size:0]   fill_count_merged,
    output logic                    mask_full
);
    localparam logic [counter_size:0] BUF_SIZE_W = (counter_size+1)'(buffer_size);

    logic [counter_size-1:0] index;
    logic                    unused_adr;

    assign index      = ramadrs[2*counter_size:counter_size+1];
    assign unused_adr = ^ramadrs[counter_size:0];
    assign write_en   = !oeenable && ({1'b0, index} < BUF_SIZE_W);

    always_comb begin
        bank_merged       = bank_q;
        mask_merged       = mask_q;
        fill_count_merged = fill_count_q;
        for (int unsigned i = 0; i < buffer_size; i++) begin
            if (write_en && ({1'b0, index} == (counter_size+1)'(i))) begin
                bank_merged[i] = txda;
                mask_merged[i] = 1'b1;
                if (!mask_q[i]) begin
                    fill_count_merged = fill_count_q + (counter_size+1)'(1);
                end
            end
        end
    end

    assign mask_full = &mask_merged;

endmodule

// File: rtl/serial_frame_store.sv
// Serial bit capture into a fill bank with one frame of elastic output buffering.
// STORE_PARITY_EN adds a registered XOR of buffer on the output interface.
module serial_frame_store
    import serial_frame_store_pkg::*;
#(
    parameter int unsigned counter_size = DEF_COUNTER_SIZE,
    parameter int unsigned buffer_size  = DEF_BUFFER_SIZE,
    parameter bit          partial_ok   = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    oeenable,
    input  logic [2*counter_size:0] ramadrs,
    input  logic                    txda,
    input  logic                    frame_end,
    output logic [counter_size:0]   fill_count,
    output logic                    overflow,
    serial_frame_store_if.master    out_if
);
    state_e                 state_q, state_d;
    logic [buffer_size-1:0] bank_q, bank_d;
    logic [buffer_size-1:0] mask_q, mask_d;
    logic [counter_size:0]  fill_count_q, fill_count_d;
    logic [buffer_size-1:0] buffer_q, buffer_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q, overflow_d;

    logic                   write_en;
    logic [buffer_size-1:0] bank_merged;
    logic [buffer_size-1:0] mask_merged;
    logic [counter_size:0]  fill_count_merged;
    logic                   mask_full;
    logic                   consume;
    logic                   complete;

    bit_write_decoder #(
        .counter_size (counter_size),
        .buffer_size  (buffer_size)
    ) u_decoder (
        .oeenable          (oeenable),
        .ramadrs           (ramadrs),
        .txda              (txda),
        .bank_q            (bank_q),
        .mask_q            (mask_q),
        .fill_count_q      (fill_count_q),
        .write_en          (write_en),
        .bank_merged       (bank_merged),
        .mask_merged       (mask_merged),
        .fill_count_merged (fill_count_merged),
        .mask_full         (mask_full)
    );

    assign consume  = out_valid_q && out_if.out_ready;
    assign complete = mask_full || (frame_end && partial_ok);

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        mask_d       = mask_q;
        fill_count_d = fill_count_q;
        buffer_d     = buffer_q;
        out_valid_d  = out_valid_q;
        overflow_d   = overflow_q;
        unique case (state_q)
            ST_FILL: begin
                bank_d       = bank_merged;
                mask_d       = mask_merged;
                fill_count_d = fill_count_merged;
                if (consume) begin
                    out_valid_d = 1'b0;
                end
                if (complete) begin
                    if (!out_valid_q || consume) begin
                        buffer_d     = bank_merged;
                        out_valid_d  = 1'b1;
                        bank_d       = '0;
                        mask_d       = '0;
                        fill_count_d = '0;
                    end else begin
                        // Slot busy: keep the merged bank frozen until the consumer drains.
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (write_en) begin
                    overflow_d = 1'b1;
                end
                if (consume) begin
                    buffer_d     = bank_q;
                    bank_d       = '0;
                    mask_d       = '0;
                    fill_count_d = '0;
                    state_d      = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            bank_q       <= '0;
            mask_q       <= '0;
            fill_count_q <= '0;
            buffer_q     <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            mask_q       <= mask_d;
            fill_count_q <= fill_count_d;
            buffer_q     <= buffer_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef STORE_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^buffer_d;
        end
    end

    assign out_if.buffer_parity = parity_q;
`endif

    assign out_if.out_valid = out_valid_q;
    assign out_if.buffer    = buffer_q;
    assign fill_count       = fill_count_q;
    assign overflow         = overflow_q;

endmodule
